sseg_scan_decoder: RTL and testbench

Receive-side counterpart of the board's multiplexed seven-segment drivers. Samples an externally scanned, active-low anode/segment bus, qualifies each digit by dwell time, rebuilds the full 4-digit frame and reports completed and changed frames. Used for board-to-board display loopback, display self-test, and as a scoreboard front-end in benches for the heartbeat and other sseg drivers.

---
 rtl/sseg_pkg.sv | 38 +++
 rtl/sseg_sync.sv | 28 ++
 rtl/sseg_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan decoder: frame layout,
// FSM state encoding and the anode-to-digit decode.
package sseg_pkg;

    typedef logic [3:0][7:0] frame_t;

    localparam logic [7:0] BLANK_SEG = 8'hFF;
    localparam logic [3:0] AN_NONE   = 4'hF;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] index;
        logic       illegal;
    } an_dec_t;

    // Exactly one low anode selects a digit; all-high is a blank slot.
    function automatic an_dec_t an_decode(input logic [3:0] an);
        an_dec_t d;
        d.valid   = 1'b0;
        d.index   = 2'd0;
        d.illegal = 1'b0;
        case (an)
            4'b1110: begin d.valid = 1'b1; d.index = 2'd0; end
            4'b1101: begin d.valid = 1'b1; d.index = 2'd1; end
            4'b1011: begin d.valid = 1'b1; d.index = 2'd2; end
            4'b0111: begin d.valid = 1'b1; d.index = 2'd3; end
            AN_NONE: d.illegal = 1'b0;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sseg_sync.sv
// Two-flop synchronizer for a bus of asynchronous inputs with a
// configurable reset value.
module sseg_sync #(
    parameter int unsigned           WIDTH     = 12,
    parameter logic [WIDTH-1:0]      RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sseg_scan_decoder.sv
// Rebuilds a 4-digit frame from an externally scanned, active-low seven-segment
// bus; each digit is accepted once per stable window of DWELL_MIN cycles.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned DWELL_MIN   = 16,
    parameter int unsigned TIMEOUT_W   = 20,
    parameter int unsigned TIMEOUT_VAL = 1000000,
    parameter logic [3:0]  FRAME_MASK  = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an_in,
    input  logic [7:0]  seg_in,
    output logic [31:0] digit_out,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        scan_active,
    output logic        illegal_an
);

    localparam int unsigned CNT_W = $clog2(DWELL_MIN + 1);

    logic [11:0]          w_s;
    logic [11:0]          r_p;
    logic [CNT_W-1:0]     r_cnt;
    state_t               r_state;
    logic [TIMEOUT_W-1:0] r_idle;
    frame_t               r_shadow;
    logic [3:0]           r_seen;
    frame_t               r_digit;
    logic                 r_fv;
    logic                 r_fc;
    logic                 r_ill;
    logic                 r_active;

    logic                 w_diff;
    logic                 w_event;
    an_dec_t              w_dec;
    logic                 w_capture;
    logic                 w_illegal;
    logic                 w_complete;
    logic                 w_timeout;
    frame_t               w_shadow_upd;
    logic [3:0]           w_seen_upd;

    sseg_sync #(
        .WIDTH     (12),
        .RESET_VAL (12'hFFF)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({an_in, seg_in}),
        .o_q   (w_s)
    );

    assign w_diff    = (w_s != r_p);
    assign w_event   = (r_state == SETTLE) && !w_diff && (r_cnt == CNT_W'(DWELL_MIN - 1));
    assign w_dec     = an_decode(w_s[11:8]);
    assign w_capture = w_event && w_dec.valid;
    assign w_illegal = w_event && w_dec.illegal;

    always_comb begin
        w_shadow_upd = r_shadow;
        w_seen_upd   = r_seen;
        if (w_capture) begin
            w_shadow_upd[w_dec.index] = w_s[7:0];
            w_seen_upd                = r_seen | (4'b0001 << w_dec.index);
        end
    end

    assign w_complete = w_capture && ((w_seen_upd & FRAME_MASK) == FRAME_MASK);
    // Fires on the edge where the idle count reaches TIMEOUT_VAL; a capture pre-empts it.
    assign w_timeout  = !w_capture && (r_idle == TIMEOUT_W'(TIMEOUT_VAL - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p     <= 12'hFFF;
            r_cnt   <= '0;
            r_state <= SETTLE;
        end else begin
            r_p <= w_s;
            if (w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_W'(DWELL_MIN)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                SETTLE:  if (w_event) r_state <= HOLD;
                HOLD:    if (w_diff)  r_state <= SETTLE;
                default: r_state <= SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= {4{BLANK_SEG}};
            r_seen   <= '0;
            r_digit  <= {4{BLANK_SEG}};
            r_fv     <= 1'b0;
            r_fc     <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_upd;
            r_fv     <= w_complete;
            r_fc     <= w_complete && (w_shadow_upd != r_digit);
            r_ill    <= w_illegal;
            if (w_complete) begin
                r_digit <= w_shadow_upd;
            end
            if (w_complete || w_timeout) begin
                r_seen <= '0;
            end else begin
                r_seen <= w_seen_upd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle   <= '0;
            r_active <= 1'b0;
        end else begin
            if (w_capture) begin
                r_idle   <= '0;
                r_active <= 1'b1;
            end else begin
                if (r_idle != TIMEOUT_W'(TIMEOUT_VAL)) begin
                    r_idle <= r_idle + 1'b1;
                end
                if (w_timeout) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

    assign digit_out     = r_digit;
    assign frame_valid   = r_fv;
    assign frame_changed = r_fc;
    assign scan_active   = r_active;
    assign illegal_an    = r_ill;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: a sample-history model of the scan bus
// is compared every cycle, plus literal expectations for each scenario.
module tb_sseg_scan_decoder;

    localparam int unsigned DWELL = 4;
    localparam int unsigned TO    = 64;
    localparam logic [3:0]  MASK  = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an_in = 4'hF;
    logic [7:0]  seg_in = 8'hFF;
    logic [31:0] digit_out;
    logic        frame_valid;
    logic        frame_changed;
    logic        scan_active;
    logic        illegal_an;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fc_cnt = 0;
    int ill_cnt = 0;
    int fv_cyc = -1;
    int fall_cyc = -1;
    bit prev_active = 1'b0;

    // Model state: pin samples two edges back feed a run-length qualifier.
    logic [11:0] m_d1 = 12'hFFF;
    logic [11:0] m_d2 = 12'hFFF;
    logic [11:0] m_prev = 12'hFFF;
    int          m_run = 1000;
    logic [7:0]  m_shadow [4];
    logic [7:0]  m_digit [4];
    bit          m_seen [4];
    int          m_idle = 0;
    bit          m_active = 1'b0;
    bit          m_fv = 1'b0;
    bit          m_fc = 1'b0;
    bit          m_ill = 1'b0;

    sseg_scan_decoder #(
        .DWELL_MIN   (DWELL),
        .TIMEOUT_W   (20),
        .TIMEOUT_VAL (TO),
        .FRAME_MASK  (MASK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .an_in         (an_in),
        .seg_in        (seg_in),
        .digit_out     (digit_out),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .scan_active   (scan_active),
        .illegal_an    (illegal_an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_d1 = 12'hFFF;
        m_d2 = 12'hFFF;
        m_prev = 12'hFFF;
        m_run = 1000;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 8'hFF;
            m_digit[i] = 8'hFF;
            m_seen[i] = 1'b0;
        end
        m_idle = 0;
        m_active = 1'b0;
        m_fv = 1'b0;
        m_fc = 1'b0;
        m_ill = 1'b0;
    endfunction

    function automatic void model_step(input logic [11:0] pin);
        logic [11:0] v;
        logic [3:0]  mask;
        bit          cap;
        bit          all;
        bit          changed;
        int          zeros;
        int          idx;
        v = m_d2;
        mask = MASK;
        cap = 1'b0;
        zeros = 0;
        idx = 0;
        m_fv = 1'b0;
        m_fc = 1'b0;
        m_ill = 1'b0;
        if (v == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = v;
        // A value seen on DWELL+1 consecutive edges is accepted once.
        if (m_run == DWELL + 1) begin
            for (int i = 0; i < 4; i++) begin
                if (!v[8+i]) begin
                    zeros++;
                    idx = i;
                end
            end
            if (zeros == 1) begin
                cap = 1'b1;
                m_shadow[idx] = v[7:0];
                m_seen[idx] = 1'b1;
                all = 1'b1;
                for (int i = 0; i < 4; i++) if (mask[i] && !m_seen[i]) all = 1'b0;
                if (all) begin
                    changed = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (m_digit[i] != m_shadow[i]) changed = 1'b1;
                        m_digit[i] = m_shadow[i];
                        m_seen[i] = 1'b0;
                    end
                    m_fv = 1'b1;
                    m_fc = changed;
                end
            end else if (zeros > 1) begin
                m_ill = 1'b1;
            end
        end
        if (cap) begin
            m_idle = 0;
            m_active = 1'b1;
        end else if (m_idle < TO) begin
            m_idle++;
            if (m_idle == TO) begin
                m_active = 1'b0;
                for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
            end
        end
        m_d2 = m_d1;
        m_d1 = pin;
    endfunction

    always begin
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else model_step({an_in, seg_in});
        #1;
        check("digit_out", digit_out, {m_digit[3], m_digit[2], m_digit[1], m_digit[0]});
        check("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
        check("frame_changed", {31'd0, frame_changed}, {31'd0, m_fc});
        check("illegal_an", {31'd0, illegal_an}, {31'd0, m_ill});
        check("scan_active", {31'd0, scan_active}, {31'd0, m_active});
        if (frame_valid) begin
            fv_cnt++;
            fv_cyc = cyc;
        end
        if (frame_changed) fc_cnt++;
        if (illegal_an) ill_cnt++;
        if (prev_active && !scan_active) fall_cyc = cyc;
        prev_active = scan_active;
    end

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n, output int k);
        an_in = an;
        seg_in = seg;
        k = cyc + 1;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] s3, output int k3);
        int k;
        hold(4'b1110, s0, 8, k);
        hold(4'b1101, s1, 8, k);
        hold(4'b1011, s2, 8, k);
        hold(4'b0111, s3, 8, k3);
    endtask

    initial begin
        int k;
        int k3;
        int fv_base;
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_digit", digit_out, 32'hFFFF_FFFF);
        check("reset_active", {31'd0, scan_active}, 32'd0);
        check("reset_fv", {31'd0, frame_valid}, 32'd0);
        reset = 1'b0;
        hold(4'hF, 8'hFF, 4, k);

        // First full scan.
        scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0, k3);
        check("t1_fv_count", fv_cnt, 1);
        check("t1_fc_count", fc_cnt, 1);
        check("t1_digit", digit_out, 32'hB0A4F9C0);
        check("t1_fv_edge", fv_cyc, k3 + 6);
        check("t1_active", {31'd0, scan_active}, 32'd1);

        // Identical scan: valid without change.
        scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0, k3);
        check("t2_fv_count", fv_cnt, 2);
        check("t2_fc_count", fc_cnt, 1);
        check("t2_digit", digit_out, 32'hB0A4F9C0);

        // Short glitch on digit 0 must not be captured.
        hold(4'b1110, 8'hC0, 8, k);
        hold(4'b1110, 8'h00, 3, k);
        hold(4'b1101, 8'hF9, 8, k);
        hold(4'b1011, 8'hA4, 8, k);
        hold(4'b0111, 8'hB0, 8, k);
        check("t3_fv_count", fv_cnt, 3);
        check("t3_fc_count", fc_cnt, 1);
        check("t3_digit", digit_out, 32'hB0A4F9C0);

        // Illegal anode mid-frame leaves the partial frame intact.
        hold(4'b1110, 8'h99, 8, k);
        hold(4'b1101, 8'h92, 8, k);
        hold(4'b0011, 8'h55, 8, k);
        check("t4_ill_count", ill_cnt, 1);
        check("t4_fv_count", fv_cnt, 3);
        hold(4'b1011, 8'h82, 8, k);
        hold(4'b0111, 8'hF8, 8, k);
        check("t4_fv_after", fv_cnt, 4);
        check("t4_fc_after", fc_cnt, 2);
        check("t4_digit", digit_out, 32'hF8829299);

        // Scan loss after two digits drops the partial frame.
        hold(4'b1110, 8'h11, 8, k);
        hold(4'b1101, 8'h22, 8, k);
        hold(4'hF, 8'hFF, 70, k3);
        check("t5_fall_edge", fall_cyc, k + 6 + 64);
        check("t5_active", {31'd0, scan_active}, 32'd0);
        check("t5_digit", digit_out, 32'hF8829299);
        hold(4'b1011, 8'h33, 8, k);
        hold(4'b0111, 8'h44, 8, k);
        check("t5_fv_count", fv_cnt, 4);
        check("t5_active_back", {31'd0, scan_active}, 32'd1);
        hold(4'b1110, 8'h55, 8, k);
        hold(4'b1101, 8'h66, 8, k);
        check("t5_fv_done", fv_cnt, 5);
        check("t5_digit_done", digit_out, 32'h44336655);

        // Reset with three digits pending discards them.
        hold(4'b1110, 8'h01, 8, k);
        hold(4'b1101, 8'h02, 8, k);
        hold(4'b1011, 8'h03, 8, k);
        an_in = 4'hF;
        seg_in = 8'hFF;
        reset = 1'b1;
        #1;
        check("t6_digit", digit_out, 32'hFFFF_FFFF);
        check("t6_active", {31'd0, scan_active}, 32'd0);
        check("t6_fv", {31'd0, frame_valid}, 32'd0);
        check("t6_ill", {31'd0, illegal_an}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        fv_base = fv_cnt;
        hold(4'b0111, 8'h04, 8, k);
        check("t6_no_frame", fv_cnt, fv_base);
        hold(4'b1110, 8'h0A, 8, k);
        hold(4'b1101, 8'h0B, 8, k);
        check("t6_still_none", fv_cnt, fv_base);
        hold(4'b1011, 8'h0C, 8, k);
        check("t6_frame", fv_cnt, fv_base + 1);
        check("t6_digit_new", digit_out, 32'h040C0B0A);

        hold(4'hF, 8'hFF, 4, k);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
